// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings and pipeline control bundles for ctrl_pipe.
//   ALUOp classes, pc_src and forward-select encodings, and the packed
//   control structs held in the ID/EX, EX/MEM and MEM/WB registers along
//   with their bubble values. Register indices live outside the structs so
//   the index width can stay a module parameter.
package ctrl_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef enum logic [1:0] {
      PCSRC_SEQ = 2'b00,
      PCSRC_BR  = 2'b01,
      PCSRC_J   = 2'b10
   } pc_src_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef struct packed {
      logic       valid;
      logic       reg_dst;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       memto_reg;
      logic       reg_write;
   } idex_ctrl_t;

   typedef struct packed {
      logic mem_read;
      logic mem_write;
      logic branch;
      logic memto_reg;
      logic reg_write;
      logic zero;
   } exmem_ctrl_t;

   typedef struct packed {
      logic memto_reg;
      logic reg_write;
   } memwb_ctrl_t;

   localparam idex_ctrl_t  IDEX_BUBBLE  = '0;
   localparam exmem_ctrl_t EXMEM_BUBBLE = '0;
   localparam memwb_ctrl_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/hazard_unit.sv
// hazard_unit: load-use / RAW stall detection and ALU operand forwarding.
//   Build option: define FWD_EN to enable the forwarding unit. Without it
//   the forward selects are tied to FWD_RF and any RAW against a writer in
//   EX or MEM stalls instead.
// Ports:
//   i_id_valid, i_id_rs, i_id_rt         instruction in ID
//   i_ex_rs, i_ex_rt                     source indices of the EX instruction
//   i_ex_dst, i_ex_reg_write, i_ex_mem_read   destination/controls in EX
//   i_mem_dst, i_mem_reg_write           destination/controls in MEM
//   i_wb_dst, i_wb_reg_write             destination/controls in WB
//   o_stall                              hazard requires a bubble
//   o_fwd_a, o_fwd_b                     operand selects for ex_rs / ex_rt
module hazard_unit
   import ctrl_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic             i_id_valid,
   input  logic [REG_W-1:0] i_id_rs,
   input  logic [REG_W-1:0] i_id_rt,
   input  logic [REG_W-1:0] i_ex_rs,
   input  logic [REG_W-1:0] i_ex_rt,
   input  logic [REG_W-1:0] i_ex_dst,
   input  logic             i_ex_reg_write,
   input  logic             i_ex_mem_read,
   input  logic [REG_W-1:0] i_mem_dst,
   input  logic             i_mem_reg_write,
   input  logic [REG_W-1:0] i_wb_dst,
   input  logic             i_wb_reg_write,
   output logic             o_stall,
   output logic [1:0]       o_fwd_a,
   output logic [1:0]       o_fwd_b
);

   // r0 is hard-wired zero, so it never creates a dependency.
   function automatic logic hit(input logic [REG_W-1:0] dst, input logic [REG_W-1:0] src);
      return (dst != '0) && (dst == src);
   endfunction

   logic w_load_use;
   assign w_load_use = i_id_valid & i_ex_mem_read &
                       (hit(i_ex_dst, i_id_rs) | hit(i_ex_dst, i_id_rt));

`ifdef FWD_EN
   // EX/MEM holds the younger result, so it wins over MEM/WB.
   always_comb begin
      o_fwd_a = FWD_RF;
      o_fwd_b = FWD_RF;
      if (i_mem_reg_write & hit(i_mem_dst, i_ex_rs))     o_fwd_a = FWD_MEM;
      else if (i_wb_reg_write & hit(i_wb_dst, i_ex_rs))  o_fwd_a = FWD_WB;
      if (i_mem_reg_write & hit(i_mem_dst, i_ex_rt))     o_fwd_b = FWD_MEM;
      else if (i_wb_reg_write & hit(i_wb_dst, i_ex_rt))  o_fwd_b = FWD_WB;
   end

   assign o_stall = w_load_use;

   logic w_unused;
   assign w_unused = i_ex_reg_write;
`else
   // Without forwarding, wait until the producer reaches WB; the register
   // file writes before it reads, so WB itself needs no stall.
   logic w_raw;
   assign w_raw = i_id_valid &
                  ((i_ex_reg_write  & (hit(i_ex_dst,  i_id_rs) | hit(i_ex_dst,  i_id_rt))) |
                   (i_mem_reg_write & (hit(i_mem_dst, i_id_rs) | hit(i_mem_dst, i_id_rt))));

   assign o_stall = w_load_use | w_raw;
   assign o_fwd_a = FWD_RF;
   assign o_fwd_b = FWD_RF;

   logic w_unused;
   assign w_unused = ^{i_ex_rs, i_ex_rt, i_wb_dst, i_wb_reg_write};
`endif

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries decoded control from ID through ID/EX, EX/MEM and
//   MEM/WB, drives each stage's controls, inserts bubbles on hazards and
//   redirects the PC on taken branches (resolved in MEM) and jumps (in ID).
//   Build option: FWD_EN enables operand forwarding (see hazard_unit).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_*                     decoder outputs and register fields of ID
//   ex_zero                  ALU zero flag of the instruction in EX
//   ex_RegDst/ALUSrc/ALUOp   EX mux selects and ALU class
//   ex_rs, ex_rt             EX source indices
//   mem_MemRead/MemWrite     data-memory strobes
//   wb_RegWrite/MemtoReg/dst write-back controls
//   stall, if_flush, pc_src  front-end control (combinational)
//   fwd_a, fwd_b             ALU operand forward selects (combinational)
module ctrl_pipe
   import ctrl_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic             id_RegDst,
   input  logic             id_ALUSrc,
   input  logic             id_MemtoReg,
   input  logic             id_RegWrite,
   input  logic             id_MemRead,
   input  logic             id_MemWrite,
   input  logic             id_Branch,
   input  logic             id_Jump,
   input  logic [1:0]       id_ALUOp,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic [REG_W-1:0] id_rd,
   input  logic             ex_zero,
   output logic             ex_RegDst,
   output logic             ex_ALUSrc,
   output logic [1:0]       ex_ALUOp,
   output logic [REG_W-1:0] ex_rs,
   output logic [REG_W-1:0] ex_rt,
   output logic             mem_MemRead,
   output logic             mem_MemWrite,
   output logic             wb_RegWrite,
   output logic             wb_MemtoReg,
   output logic [REG_W-1:0] wb_dst,
   output logic             stall,
   output logic             if_flush,
   output logic [1:0]       pc_src,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b
);

   idex_ctrl_t       r_idex;
   logic [REG_W-1:0] r_ex_rs, r_ex_rt, r_ex_rd;
   exmem_ctrl_t      r_exmem;
   logic [REG_W-1:0] r_mem_dst;
   memwb_ctrl_t      r_memwb;
   logic [REG_W-1:0] r_wb_dst;

   logic [REG_W-1:0] w_ex_dst;
   logic             w_branch_taken;
   logic             w_hz_stall;
   logic             w_idex_load;
   logic [1:0]       w_fwd_a, w_fwd_b;

   assign w_ex_dst       = r_idex.reg_dst ? r_ex_rd : r_ex_rt;
   assign w_branch_taken = r_exmem.branch & r_exmem.zero;
   // Jumps redirect from ID and never need EX, so they enter ID/EX as bubbles.
   assign w_idex_load    = id_valid & ~id_Jump & ~w_hz_stall & ~w_branch_taken;

   hazard_unit #(.REG_W(REG_W)) u_hazard (
      .i_id_valid      (id_valid),
      .i_id_rs         (id_rs),
      .i_id_rt         (id_rt),
      .i_ex_rs         (r_ex_rs),
      .i_ex_rt         (r_ex_rt),
      .i_ex_dst        (w_ex_dst),
      .i_ex_reg_write  (r_idex.reg_write),
      .i_ex_mem_read   (r_idex.mem_read),
      .i_mem_dst       (r_mem_dst),
      .i_mem_reg_write (r_exmem.reg_write),
      .i_wb_dst        (r_wb_dst),
      .i_wb_reg_write  (r_memwb.reg_write),
      .o_stall         (w_hz_stall),
      .o_fwd_a         (w_fwd_a),
      .o_fwd_b         (w_fwd_b)
   );

   // Priority: taken branch > stall > jump. A stalled jump waits in ID.
   // Reset masks everything so nothing redirects while the pipe is cleared.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      stall    = 1'b0;
      if_flush = 1'b0;
      pc_src   = PCSRC_SEQ;
      fwd_a    = FWD_RF;
      fwd_b    = FWD_RF;
      if (!rst) begin
         fwd_a = w_fwd_a;
         fwd_b = w_fwd_b;
         if (w_branch_taken) begin
            pc_src   = PCSRC_BR;
            if_flush = 1'b1;
         end else if (w_hz_stall) begin
            stall = 1'b1;
         end else if (id_valid & id_Jump) begin
            pc_src   = PCSRC_J;
            if_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every stage samples pre-edge values.
      if (rst) begin
         r_idex    <= IDEX_BUBBLE;
         r_ex_rs   <= '0;
         r_ex_rt   <= '0;
         r_ex_rd   <= '0;
         r_exmem   <= EXMEM_BUBBLE;
         r_mem_dst <= '0;
         r_memwb   <= MEMWB_BUBBLE;
         r_wb_dst  <= '0;
      end else begin
         if (w_idex_load) begin
            r_idex  <= '{valid: 1'b1, reg_dst: id_RegDst, alu_src: id_ALUSrc,
                         alu_op: id_ALUOp, mem_read: id_MemRead,
                         mem_write: id_MemWrite, branch: id_Branch,
                         memto_reg: id_MemtoReg, reg_write: id_RegWrite};
            r_ex_rs <= id_rs;
            r_ex_rt <= id_rt;
            r_ex_rd <= id_rd;
         end else begin
            r_idex  <= IDEX_BUBBLE;
            r_ex_rs <= '0;
            r_ex_rt <= '0;
            r_ex_rd <= '0;
         end

         // The branch in MEM squashes the instruction behind it in EX.
         if (w_branch_taken) begin
            r_exmem   <= EXMEM_BUBBLE;
            r_mem_dst <= '0;
         end else begin
            r_exmem   <= '{mem_read: r_idex.mem_read, mem_write: r_idex.mem_write,
                           branch: r_idex.branch, memto_reg: r_idex.memto_reg,
                           reg_write: r_idex.reg_write,
                           zero: ex_zero & r_idex.valid};
            r_mem_dst <= w_ex_dst;
         end

         r_memwb  <= '{memto_reg: r_exmem.memto_reg, reg_write: r_exmem.reg_write};
         r_wb_dst <= r_mem_dst;
      end
   end

   assign ex_RegDst    = r_idex.reg_dst;
   assign ex_ALUSrc    = r_idex.alu_src;
   assign ex_ALUOp     = r_idex.alu_op;
   assign ex_rs        = r_ex_rs;
   assign ex_rt        = r_ex_rt;
   assign mem_MemRead  = r_exmem.mem_read;
   assign mem_MemWrite = r_exmem.mem_write;
   assign wb_RegWrite  = r_memwb.reg_write;
   assign wb_MemtoReg  = r_memwb.memto_reg;
   assign wb_dst       = r_wb_dst;

endmodule
